// File: rtl/datapath_pkg.sv
// Shared scalar-pipe types: FU row ids, FUST row states, row payload and tag helpers.
package datapath_pkg;

    localparam int S_TAG_W = 2;

    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_LD_ST  = 2'd1,
        FU_BRANCH = 2'd2,
        FU_NONE   = 2'd3
    } fu_scalar_t;

    typedef enum logic [1:0] {
        FUST_EMPTY = 2'd0,
        FUST_WAIT  = 2'd1,
        FUST_RDY   = 2'd2,
        FUST_EX    = 2'd3
    } fust_state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fust_s_row_t;

    localparam logic [S_TAG_W-1:0] TAG_READY = '0;

    // Tag k names FU row k-1, so tag 0 is free to mean "operand ready".
    function automatic logic [S_TAG_W-1:0] fu2tag(input logic [1:0] fu);
        return S_TAG_W'(fu + 2'd1);
    endfunction

endpackage

// File: rtl/fust_s_row.sv
// One FUST row: state, payload and producer tags, with writeback wakeup and dispatch bypass.
//   state      | meaning
//   FUST_EMPTY | row free, may accept a dispatch
//   FUST_WAIT  | holding op, at least one producer tag outstanding
//   FUST_RDY   | all operands ready, candidate for issue
//   FUST_EX    | issued, waiting for own writeback
module fust_s_row
    import datapath_pkg::*;
#(
    parameter int               TAG_W   = S_TAG_W,
    parameter logic [TAG_W-1:0] ROW_TAG = '0
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_disp_we,
    input  fust_s_row_t       i_disp_op,
    input  logic [TAG_W-1:0]  i_disp_t1,
    input  logic [TAG_W-1:0]  i_disp_t2,
    input  logic              i_wb_valid,
    input  logic [TAG_W-1:0]  i_wb_tag,
    input  logic              i_issue,
    output fust_state_e       o_state,
    output fust_s_row_t       o_op
);

    fust_state_e      r_state;
    fust_state_e      w_state_nxt;
    fust_s_row_t      r_op;
    logic [TAG_W-1:0] r_t1;
    logic [TAG_W-1:0] r_t2;
    logic [TAG_W-1:0] w_t1_nxt;
    logic [TAG_W-1:0] w_t2_nxt;
    logic [TAG_W-1:0] w_disp_t1;
    logic [TAG_W-1:0] w_disp_t2;
    logic             w_own_wb;

    always_comb begin
        w_own_wb    = i_wb_valid && (i_wb_tag == ROW_TAG);
        w_disp_t1   = (i_wb_valid && i_wb_tag == i_disp_t1) ? TAG_READY : i_disp_t1;
        w_disp_t2   = (i_wb_valid && i_wb_tag == i_disp_t2) ? TAG_READY : i_disp_t2;
        w_t1_nxt    = (i_wb_valid && i_wb_tag == r_t1) ? TAG_READY : r_t1;
        w_t2_nxt    = (i_wb_valid && i_wb_tag == r_t2) ? TAG_READY : r_t2;
        w_state_nxt = r_state;
        case (r_state)
            FUST_EMPTY: begin
                if (i_disp_we) begin
                    w_t1_nxt    = w_disp_t1;
                    w_t2_nxt    = w_disp_t2;
                    w_state_nxt = (w_disp_t1 == TAG_READY && w_disp_t2 == TAG_READY)
                                  ? FUST_RDY : FUST_WAIT;
                end
            end
            FUST_WAIT: begin
                if (w_t1_nxt == TAG_READY && w_t2_nxt == TAG_READY)
                    w_state_nxt = FUST_RDY;
            end
            FUST_RDY: begin
                if (i_issue)
                    w_state_nxt = FUST_EX;
            end
            FUST_EX: begin
                if (w_own_wb)
                    w_state_nxt = FUST_EMPTY;
            end
            default: w_state_nxt = FUST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= FUST_EMPTY;
            r_t1    <= '0;
            r_t2    <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t1    <= w_t1_nxt;
            r_t2    <= w_t2_nxt;
            if (r_state == FUST_EMPTY && i_disp_we)
                r_op <= i_disp_op;
        end
    end

    // A writeback for this row is only legal while the row is executing.
    a_wb_only_in_ex: assert property (@(posedge i_clk) disable iff (i_clr)
        w_own_wb |-> (r_state == FUST_EX));

    assign o_state = r_state;
    assign o_op    = r_op;

endmodule

// File: rtl/fust_s_issue.sv
// Scalar FUST with fixed-priority issue select (BRANCH > LD_ST > ALU) and registered issue port.
module fust_s_issue
    import datapath_pkg::*;
#(
    parameter int NFU   = 3,
    parameter int TAG_W = S_TAG_W
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         disp_valid,
    input  fu_scalar_t                   disp_fu,
    input  fust_s_row_t                  disp_op,
    input  logic [TAG_W-1:0]             disp_t1,
    input  logic [TAG_W-1:0]             disp_t2,
    output logic [NFU-1:0]               disp_ready,
    input  logic                         wb_valid,
    input  logic [TAG_W-1:0]             wb_tag,
    input  logic                         flush,
    input  logic [NFU-1:0]               fu_ready,
    output logic                         issue_valid,
    output logic [1:0]                   issue_fu,
    output fust_s_row_t                  issue_op,
    output fust_state_e [NFU-1:0]        fust_state,
    output logic [NFU-1:0]               fust_busy
);

    logic            w_clr;
    logic [NFU-1:0]  w_disp_we;
    logic [NFU-1:0]  w_issue;
    fust_s_row_t     w_row_op [NFU];
    logic            w_sel_found;
    logic [1:0]      w_sel_idx;
    fust_s_row_t     w_sel_op;

    logic            r_issue_valid;
    logic [1:0]      r_issue_fu;
    fust_s_row_t     r_issue_op;

    assign w_clr = RST | flush;

    for (genvar g = 0; g < NFU; g++) begin : g_row
        assign disp_ready[g] = (fust_state[g] == FUST_EMPTY);
        assign fust_busy[g]  = (fust_state[g] != FUST_EMPTY);
        assign w_disp_we[g]  = disp_valid && (disp_fu != FU_NONE) && (disp_fu == 2'(g))
                               && disp_ready[g] && !flush;
        assign w_issue[g]    = w_sel_found && (w_sel_idx == 2'(g)) && !flush;

        fust_s_row #(
            .TAG_W   (TAG_W),
            .ROW_TAG (TAG_W'(fu2tag(2'(g))))
        ) u_row (
            .i_clk      (CLK),
            .i_clr      (w_clr),
            .i_disp_we  (w_disp_we[g]),
            .i_disp_op  (disp_op),
            .i_disp_t1  (disp_t1),
            .i_disp_t2  (disp_t2),
            .i_wb_valid (wb_valid),
            .i_wb_tag   (wb_tag),
            .i_issue    (w_issue[g]),
            .o_state    (fust_state[g]),
            .o_op       (w_row_op[g])
        );
    end

    // Ascending scan: the last hit is the highest row index, i.e. BRANCH wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_op    = '0;
        for (int i = 0; i < NFU; i++) begin
            if (fust_state[i] == FUST_RDY && fu_ready[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = 2'(i);
                w_sel_op    = w_row_op[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_issue_valid <= 1'b0;
            r_issue_fu    <= '0;
            r_issue_op    <= '0;
        end else if (flush) begin
            r_issue_valid <= 1'b0;
        end else begin
            r_issue_valid <= w_sel_found;
            if (w_sel_found) begin
                r_issue_fu <= w_sel_idx;
                r_issue_op <= w_sel_op;
            end
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_fu    = r_issue_fu;
    assign issue_op    = r_issue_op;

endmodule

// File: tb/tb_fust_s_issue.sv
// Bench for fust_s_issue: directed scenarios plus randomized traffic against a row-table model.
module tb_fust_s_issue;
    import datapath_pkg::*;

    localparam int NFU = 3;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  disp_valid;
    fu_scalar_t            disp_fu;
    fust_s_row_t           disp_op;
    logic [1:0]            disp_t1;
    logic [1:0]            disp_t2;
    logic [NFU-1:0]        disp_ready;
    logic                  wb_valid;
    logic [1:0]            wb_tag;
    logic                  flush;
    logic [NFU-1:0]        fu_ready;
    logic                  issue_valid;
    logic [1:0]            issue_fu;
    fust_s_row_t           issue_op;
    fust_state_e [NFU-1:0] fust_state;
    logic [NFU-1:0]        fust_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: per-row state, outstanding producer tags, payload; plus issue port.
    fust_state_e m_st [NFU];
    int          m_t1 [NFU];
    int          m_t2 [NFU];
    fust_s_row_t m_op [NFU];
    logic        m_iv;
    int          m_ifu;
    fust_s_row_t m_iop;

    always #5 CLK = ~CLK;

    fust_s_issue #(.NFU(NFU), .TAG_W(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .disp_valid  (disp_valid),
        .disp_fu     (disp_fu),
        .disp_op     (disp_op),
        .disp_t1     (disp_t1),
        .disp_t2     (disp_t2),
        .disp_ready  (disp_ready),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .flush       (flush),
        .fu_ready    (fu_ready),
        .issue_valid (issue_valid),
        .issue_fu    (issue_fu),
        .issue_op    (issue_op),
        .fust_state  (fust_state),
        .fust_busy   (fust_busy)
    );

    function automatic fust_s_row_t rnd_op();
        fust_s_row_t r;
        r.rd  = 5'($urandom);
        r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom);
        r.imm = $urandom;
        return r;
    endfunction

    // Drive one cycle of inputs, advance the model by the spec rules, land #1 after the edge.
    task automatic step(input logic dv, input int dfu, input int dt1, input int dt2,
                        input logic wbv, input int wbt, input logic fl, input logic rs,
                        input logic [2:0] fr, input fust_s_row_t dop);
        fust_state_e n_st [NFU];
        int          n_t1 [NFU];
        int          n_t2 [NFU];
        fust_s_row_t n_op [NFU];
        logic        n_iv;
        int          n_ifu;
        fust_s_row_t n_iop;
        int          win;
        int          e1;
        int          e2;
        RST        = rs;
        disp_valid = dv;
        disp_fu    = fu_scalar_t'(2'(dfu));
        disp_op    = dop;
        disp_t1    = 2'(dt1);
        disp_t2    = 2'(dt2);
        wb_valid   = wbv;
        wb_tag     = 2'(wbt);
        flush      = fl;
        fu_ready   = fr;
        n_st  = m_st;
        n_t1  = m_t1;
        n_t2  = m_t2;
        n_op  = m_op;
        n_iv  = m_iv;
        n_ifu = m_ifu;
        n_iop = m_iop;
        if (rs || fl) begin
            for (int i = 0; i < NFU; i++) begin
                n_st[i] = FUST_EMPTY;
                n_t1[i] = 0;
                n_t2[i] = 0;
            end
            n_iv = 1'b0;
            if (rs) begin
                n_ifu = 0;
                n_iop = '0;
            end
        end else begin
            win = -1;
            for (int i = 0; i < NFU; i++)
                if (m_st[i] == FUST_RDY && fr[i]) win = i;
            for (int i = 0; i < NFU; i++) begin
                if (wbv && m_t1[i] == wbt) n_t1[i] = 0;
                if (wbv && m_t2[i] == wbt) n_t2[i] = 0;
                if (m_st[i] == FUST_WAIT && n_t1[i] == 0 && n_t2[i] == 0) n_st[i] = FUST_RDY;
                if (m_st[i] == FUST_RDY && win == i) n_st[i] = FUST_EX;
                if (m_st[i] == FUST_EX && wbv && wbt == i + 1) n_st[i] = FUST_EMPTY;
            end
            if (dv && dfu < NFU && m_st[dfu] == FUST_EMPTY) begin
                e1 = (wbv && wbt == dt1) ? 0 : dt1;
                e2 = (wbv && wbt == dt2) ? 0 : dt2;
                n_t1[dfu] = e1;
                n_t2[dfu] = e2;
                n_st[dfu] = (e1 == 0 && e2 == 0) ? FUST_RDY : FUST_WAIT;
                n_op[dfu] = dop;
            end
            n_iv = (win >= 0);
            if (win >= 0) begin
                n_ifu = win;
                n_iop = m_op[win];
            end
        end
        @(posedge CLK);
        #1;
        m_st  = n_st;
        m_t1  = n_t1;
        m_t2  = n_t2;
        m_op  = n_op;
        m_iv  = n_iv;
        m_ifu = n_ifu;
        m_iop = n_iop;
    endtask

    task automatic idle(input logic [2:0] fr);
        step(0, 0, 0, 0, 0, 0, 0, 0, fr, '0);
    endtask

    task automatic disp(input int fu, input int t1, input int t2, input logic [2:0] fr,
                        input fust_s_row_t op);
        step(1, fu, t1, t2, 0, 0, 0, 0, fr, op);
    endtask

    task automatic wb(input int tag, input logic [2:0] fr);
        step(0, 0, 0, 0, 1, tag, 0, 0, fr, '0);
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1, 3'b111, '0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3'b111, '0);
        checks++; if (disp_ready !== 3'b111) begin errors++; $display("FAIL reset_disp_ready: got %b expected 111", disp_ready); end
        checks++; if (fust_busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b expected 000", fust_busy); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid); end
        checks++; if (issue_fu !== 2'd0) begin errors++; $display("FAIL reset_issue_fu: got %0d expected 0", issue_fu); end
        checks++; if (issue_op !== '0) begin errors++; $display("FAIL reset_issue_op: got %h expected 0", issue_op); end
        for (int i = 0; i < NFU; i++) begin
            checks++; if (fust_state[i] !== FUST_EMPTY) begin errors++; $display("FAIL reset_state%0d: got %0d expected EMPTY", i, fust_state[i]); end
        end
        idle(3'b111);
    endtask

    task automatic test_alu_latency();
        fust_s_row_t op_a = rnd_op();
        disp(0, 0, 0, 3'b111, op_a);
        checks++; if (fust_state[0] !== FUST_RDY) begin errors++; $display("FAIL alu_c1_state: got %0d expected RDY", fust_state[0]); end
        checks++; if (disp_ready[0] !== 1'b0) begin errors++; $display("FAIL alu_c1_disp_ready: got %b expected 0", disp_ready[0]); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL alu_c1_issue_valid: got %b expected 0", issue_valid); end
        idle(3'b111);
        checks++; if (issue_valid !== 1'b1 || issue_fu !== 2'd0) begin errors++; $display("FAIL alu_c2_issue: got v=%b fu=%0d expected v=1 fu=0", issue_valid, issue_fu); end
        checks++; if (issue_op !== op_a) begin errors++; $display("FAIL alu_c2_issue_op: got %h expected %h", issue_op, op_a); end
        checks++; if (fust_state[0] !== FUST_EX) begin errors++; $display("FAIL alu_c2_state: got %0d expected EX", fust_state[0]); end
        idle(3'b111);
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL alu_c3_issue_valid: got %b expected 0", issue_valid); end
        wb(1, 3'b111);
        checks++; if (fust_state[0] !== FUST_EMPTY || disp_ready[0] !== 1'b1) begin errors++; $display("FAIL alu_c5_free: got state=%0d rdy=%b expected EMPTY/1", fust_state[0], disp_ready[0]); end
    endtask

    task automatic test_dependent_and_bypass();
        fust_s_row_t op_l = rnd_op();
        fust_s_row_t op_b = rnd_op();
        disp(0, 0, 0, 3'b111, rnd_op());
        idle(3'b111);
        disp(1, 1, 0, 3'b111, op_l);
        checks++; if (fust_state[1] !== FUST_WAIT) begin errors++; $display("FAIL dep_wait: got %0d expected WAIT", fust_state[1]); end
        idle(3'b111);
        checks++; if (fust_state[1] !== FUST_WAIT) begin errors++; $display("FAIL dep_still_wait: got %0d expected WAIT", fust_state[1]); end
        wb(1, 3'b111);
        checks++; if (fust_state[1] !== FUST_RDY || fust_state[0] !== FUST_EMPTY) begin errors++; $display("FAIL dep_wakeup: got ld=%0d alu=%0d expected RDY/EMPTY", fust_state[1], fust_state[0]); end
        idle(3'b111);
        checks++; if (issue_valid !== 1'b1 || issue_fu !== 2'd1 || issue_op !== op_l) begin errors++; $display("FAIL dep_issue: got v=%b fu=%0d op=%h expected v=1 fu=1 op=%h", issue_valid, issue_fu, issue_op, op_l); end
        step(1, 2, 0, 2, 1, 2, 0, 0, 3'b111, op_b);
        checks++; if (fust_state[2] !== FUST_RDY || fust_state[1] !== FUST_EMPTY) begin errors++; $display("FAIL bypass_state: got br=%0d ld=%0d expected RDY/EMPTY", fust_state[2], fust_state[1]); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL bypass_n1_valid: got %b expected 0", issue_valid); end
        idle(3'b111);
        checks++; if (issue_valid !== 1'b1 || issue_fu !== 2'd2 || issue_op !== op_b) begin errors++; $display("FAIL bypass_issue: got v=%b fu=%0d op=%h expected v=1 fu=2 op=%h", issue_valid, issue_fu, issue_op, op_b); end
        wb(3, 3'b111);
    endtask

    task automatic test_priority();
        int exp_seq [3] = '{2, 1, 0};
        for (int r = 0; r < NFU; r++) disp(r, 0, 0, 3'b000, rnd_op());
        checks++; if (fust_state[0] !== FUST_RDY || fust_state[1] !== FUST_RDY || fust_state[2] !== FUST_RDY) begin errors++; $display("FAIL prio_all_rdy: got %0d %0d %0d expected all RDY", fust_state[0], fust_state[1], fust_state[2]); end
        for (int k = 0; k < 3; k++) begin
            idle(3'b111);
            checks++; if (issue_valid !== 1'b1 || issue_fu !== 2'(exp_seq[k])) begin errors++; $display("FAIL prio_order%0d: got v=%b fu=%0d expected v=1 fu=%0d", k, issue_valid, issue_fu, exp_seq[k]); end
        end
        idle(3'b111);
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL prio_drain: got %b expected 0", issue_valid); end
        wb(3, 3'b111); wb(2, 3'b111); wb(1, 3'b111);
        for (int r = 0; r < NFU; r++) disp(r, 0, 0, 3'b000, rnd_op());
        idle(3'b011);
        checks++; if (issue_valid !== 1'b1 || issue_fu !== 2'd1) begin errors++; $display("FAIL prio_masked0: got v=%b fu=%0d expected v=1 fu=1", issue_valid, issue_fu); end
        idle(3'b011);
        checks++; if (issue_valid !== 1'b1 || issue_fu !== 2'd0) begin errors++; $display("FAIL prio_masked1: got v=%b fu=%0d expected v=1 fu=0", issue_valid, issue_fu); end
        idle(3'b011);
        checks++; if (issue_valid !== 1'b0 || fust_state[2] !== FUST_RDY) begin errors++; $display("FAIL prio_br_held: got v=%b br=%0d expected v=0 br=RDY", issue_valid, fust_state[2]); end
        idle(3'b111);
        checks++; if (issue_valid !== 1'b1 || issue_fu !== 2'd2) begin errors++; $display("FAIL prio_br_late: got v=%b fu=%0d expected v=1 fu=2", issue_valid, issue_fu); end
        wb(1, 3'b111); wb(2, 3'b111); wb(3, 3'b111);
    endtask

    task automatic test_wb_dispatch_collision();
        fust_s_row_t op2 = rnd_op();
        disp(0, 0, 0, 3'b111, rnd_op());
        idle(3'b111);
        step(1, 0, 0, 0, 1, 1, 0, 0, 3'b111, rnd_op());
        checks++; if (fust_state[0] !== FUST_EMPTY || disp_ready[0] !== 1'b1) begin errors++; $display("FAIL collide_reject: got state=%0d rdy=%b expected EMPTY/1", fust_state[0], disp_ready[0]); end
        disp(0, 0, 0, 3'b111, op2);
        checks++; if (fust_state[0] !== FUST_RDY) begin errors++; $display("FAIL collide_redispatch: got %0d expected RDY", fust_state[0]); end
        idle(3'b111);
        checks++; if (issue_valid !== 1'b1 || issue_op !== op2) begin errors++; $display("FAIL collide_issue_op: got v=%b op=%h expected v=1 op=%h", issue_valid, issue_op, op2); end
        wb(1, 3'b111);
    endtask

    task automatic setup_two_wait_one_ex();
        disp(0, 0, 0, 3'b111, rnd_op());
        idle(3'b111);
        disp(1, 1, 0, 3'b111, rnd_op());
        disp(2, 2, 0, 3'b111, rnd_op());
    endtask

    task automatic test_flush_and_reset();
        setup_two_wait_one_ex();
        checks++; if (fust_state[0] !== FUST_EX || fust_state[1] !== FUST_WAIT || fust_state[2] !== FUST_WAIT) begin errors++; $display("FAIL flush_setup: got %0d %0d %0d expected EX WAIT WAIT", fust_state[0], fust_state[1], fust_state[2]); end
        step(1, 1, 0, 0, 0, 0, 1, 0, 3'b111, rnd_op());
        checks++; if (fust_busy !== 3'b000 || disp_ready !== 3'b111) begin errors++; $display("FAIL flush_rows: got busy=%b rdy=%b expected 000/111", fust_busy, disp_ready); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_valid: got %b expected 0", issue_valid); end
        idle(3'b111);
        checks++; if (fust_busy !== 3'b000 || issue_valid !== 1'b0) begin errors++; $display("FAIL flush_settled: got busy=%b v=%b expected 000/0", fust_busy, issue_valid); end
        setup_two_wait_one_ex();
        step(1, 1, 0, 0, 0, 0, 0, 1, 3'b111, rnd_op());
        checks++; if (fust_busy !== 3'b000 || disp_ready !== 3'b111) begin errors++; $display("FAIL rst_rows: got busy=%b rdy=%b expected 000/111", fust_busy, disp_ready); end
        checks++; if (issue_valid !== 1'b0 || issue_fu !== 2'd0 || issue_op !== '0) begin errors++; $display("FAIL rst_issue_regs: got v=%b fu=%0d op=%h expected 0/0/0", issue_valid, issue_fu, issue_op); end
        idle(3'b111);
        disp(2, 0, 0, 3'b111, rnd_op());
        step(0, 0, 0, 0, 0, 0, 0, 1, 3'b111, '0);
        checks++; if (issue_valid !== 1'b0 || fust_state[2] !== FUST_EMPTY) begin errors++; $display("FAIL rst_pending_issue: got v=%b br=%0d expected 0/EMPTY", issue_valid, fust_state[2]); end
        idle(3'b111);
    endtask

    task automatic test_random();
        int ex_rows [$];
        int dt1;
        int dt2;
        int wbt;
        logic wbv;
        for (int c = 0; c < 600; c++) begin
            ex_rows.delete();
            for (int i = 0; i < NFU; i++) if (m_st[i] == FUST_EX) ex_rows.push_back(i);
            wbv = (ex_rows.size() > 0) && ($urandom_range(0, 2) != 0);
            wbt = wbv ? ex_rows[$urandom_range(0, ex_rows.size() - 1)] + 1 : 0;
            dt1 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            dt2 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3), dt1, dt2, wbv, wbt,
                 $urandom_range(0, 39) == 0, 1'b0, 3'($urandom_range(0, 7)), rnd_op());
            for (int i = 0; i < NFU; i++) begin
                checks++; if (fust_state[i] !== m_st[i]) begin errors++; $display("FAIL rnd_state c%0d row%0d: got %0d expected %0d", c, i, fust_state[i], m_st[i]); end
                checks++; if (disp_ready[i] !== (m_st[i] == FUST_EMPTY) || fust_busy[i] !== (m_st[i] != FUST_EMPTY)) begin errors++; $display("FAIL rnd_ready_busy c%0d row%0d: got rdy=%b busy=%b", c, i, disp_ready[i], fust_busy[i]); end
            end
            checks++; if (issue_valid !== m_iv) begin errors++; $display("FAIL rnd_issue_valid c%0d: got %b expected %b", c, issue_valid, m_iv); end
            checks++; if (issue_fu !== 2'(m_ifu) || issue_op !== m_iop) begin errors++; $display("FAIL rnd_issue_payload c%0d: got fu=%0d op=%h expected fu=%0d op=%h", c, issue_fu, issue_op, m_ifu, m_iop); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NFU; i++) begin
            m_st[i] = FUST_EMPTY;
            m_t1[i] = 0;
            m_t2[i] = 0;
            m_op[i] = '0;
        end
        m_iv  = 1'b0;
        m_ifu = 0;
        m_iop = '0;
        RST = 1'b1; disp_valid = 1'b0; disp_fu = FU_NONE; disp_op = '0;
        disp_t1 = '0; disp_t2 = '0; wb_valid = 1'b0; wb_tag = '0; flush = 1'b0; fu_ready = '0;
        @(posedge CLK);
        #1;
        test_reset();
        test_alu_latency();
        test_dependent_and_bypass();
        test_priority();
        test_wb_dispatch_collision();
        test_flush_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fust_s_issue.md
# fust_s_issue

Scalar functional-unit status table (FUST) plus issue select for the scalar pipe. It sits between dispatch and the scalar FUs (ALU, LD/ST, BRANCH). It holds one in-flight instruction per scalar FU, tracks operand-producer tags, and wakes rows on writeback. Each cycle it issues at most one ready row to its FU through a registered issue port.

## Interface
Parameters:
- NFU, 3, number of scalar FU rows; row index = fu_scalar_t value (ALU=0, LD_ST=1, BRANCH=2)
- TAG_W, 2, producer tag width; tag 0 = operand ready, tag k = produced by FU row k-1

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- disp_valid  in  1  dispatch request this cycle
- disp_fu  in  2  target row (fu_scalar_t); FU_NONE never writes a row
- disp_op  in  fust_s_row_t  rd/rs1/rs2/imm
- disp_t1, disp_t2  in  TAG_W each  source producer tags
- disp_ready  out  NFU  per-row: row state == FUST_EMPTY
- wb_valid  in  1  an FU completed
- wb_tag  in  TAG_W  completing FU as tag (1..NFU)
- flush  in  1  squash all rows (branch mispredict)
- fu_ready  in  NFU  FU can accept an issue this cycle
- issue_valid  out  1  registered; one-cycle pulse per issue
- issue_fu  out  2  registered row index issued
- issue_op  out  fust_s_row_t  registered payload
- fust_state  out  NFU x fust_state_e  per-row state, for dispatch and debug
- fust_busy  out  NFU  row state != FUST_EMPTY

## Operation
Per-row states are FUST_EMPTY, FUST_WAIT, FUST_RDY and FUST_EX.

State transitions:
- EMPTY -> WAIT/RDY on accepted dispatch. Accepted means disp_valid && disp_fu != FU_NONE && disp_ready[disp_fu].
  - Effective tags are disp_t1/disp_t2, each zeroed if wb_valid && wb_tag matches it in the same cycle (wakeup bypass).
  - Next state is RDY if both effective tags are 0, else WAIT.
- WAIT -> RDY once both stored tags are 0.
- Wakeup: on wb_valid, every row whose stored t1 or t2 equals wb_tag clears that tag. Rows in WAIT whose tags both become 0 go to RDY on the same edge.
- RDY -> EX when selected for issue.
- EX -> EMPTY on wb_valid && wb_tag == row+1.
- wb_tag naming a row not in EX: state unchanged; assertion fires. Tag clearing in other rows still applies.

Issue select:
- Candidates are rows in RDY with fu_ready[row]=1.
- Fixed priority: BRANCH > LD_ST > ALU.
- The winner's op/index is loaded into the issue registers and issue_valid=1 next cycle. The row moves to EX on the same edge.
- With no candidate, issue_valid=0 and issue_op/issue_fu hold their last value.

Precedence, highest first: RST > flush > (wb, dispatch, issue).
- flush: all rows EMPTY, all tags 0, issue_valid 0 next cycle; dispatch and wb that cycle are dropped.
- A wb freeing a row and a dispatch to that row in the same cycle: dispatch is rejected, because disp_ready reflects the current state only.

Reset values: all rows EMPTY, tags 0, op 0, issue_valid 0, issue_fu 0, issue_op 0, disp_ready all 1, fust_busy 0.

## Timing
- disp_ready, fust_state and fust_busy are combinational from state registers; they do not depend on same-cycle wb.
- Dispatch with both tags 0 in cycle N -> row RDY in N+1 -> issue_valid in N+2 (if fu_ready and highest priority).
- Dependent op:
  - WAIT row, wb in cycle M -> RDY in M+1 -> issue_valid in M+2.
  - With the bypass (wb in the dispatch cycle N), issue_valid is in N+2.
- Issue throughput: one per cycle.
- Row occupancy: from dispatch to the cycle after its own wb. Minimum 3 cycles (dispatch, RDY, EX with wb).
- RST asserted mid-operation: state clears on that edge; issue_valid is 0 in the following cycle regardless of a pending issue.

## Structure
- Shared package (datapath_pkg): fust_state_e, fust_s_row_t, fu_scalar_t, plus new localparams TAG_READY='0 and a function fu2tag(fu) = fu+1. Nothing module-local duplicates these.
- Sub-module fust_s_row: one row's state register, op and tags, with wakeup and bypass logic. Instantiated NFU times.
- Top: dispatch decode, priority select, issue registers and the flush/reset fan-out.

## Test plan
- ALU dispatch, t1=t2=0, cycle 0, fu_ready=3'b111 -> issue_valid=1, issue_fu=0 in cycle 2; state EX; wb_tag=1 in cycle 4 -> ALU row EMPTY and disp_ready[0]=1 in cycle 5.
- LD_ST dispatch with t1=1 while the ALU row is in EX; wb_tag=1 in cycle 6 -> LD_ST RDY cycle 7, issue_valid cycle 8 with issue_fu=1.
- Bypass: dispatch BRANCH with t2=2 and wb_tag=2 in the same cycle -> BRANCH row enters RDY directly, issues 2 cycles later.
- ALU, LD_ST and BRANCH all RDY in the same cycle with fu_ready=3'b111 -> issues in order BRANCH, LD_ST, ALU on 3 consecutive cycles. Repeat with fu_ready[2]=0 -> LD_ST first; BRANCH stays RDY.
- Dispatch to an ALU row in EX, with wb_tag=1 the same cycle -> dispatch rejected; row EMPTY next cycle; re-dispatch accepted.
- flush with two rows WAIT and one EX, plus a simultaneous dispatch -> all rows EMPTY and issue_valid=0 next cycle. Same sequence with RST -> all outputs at reset values.
